// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit and its environment: instruction ROM port,
// decode-side valid/ready stream, redirect request and completion flag.
interface instr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        done;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, done,
    input  imem_data, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, done,
    output imem_data, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational ROM and buffers
// {pc, instr} pairs in a prefetch FIFO feeding decode; redirects flush the FIFO.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] END_PC     = 32'd360,
  parameter logic [31:0] PC_STEP    = 32'd4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t          state, state_next;
  logic [31:0]     pc;
  logic [31:0]     pc_inc;
  logic [31:0]     redirect_target;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic            done_q;
  logic            push, pop, valid_int;
  logic [31:0]     fifo_pc    [FIFO_DEPTH];
  logic [31:0]     fifo_instr [FIFO_DEPTH];

  assign redirect_target = {bus.redirect_pc[31:2], 2'b00};
  assign pc_inc          = pc + PC_STEP;
  assign valid_int       = (count != '0) && (state != DONE);
  assign pop             = valid_int && bus.out_ready;
  // A full FIFO may still accept a word when its head leaves in the same cycle.
  assign push            = (state == RUN) && (pc < END_PC) && !bus.redirect_valid &&
                           ((count < FULL) || pop);

  always_comb begin
    count_next = count;
    if (push && !pop) count_next = count + CW'(1);
    if (pop && !push) count_next = count - CW'(1);
  end

  always_comb begin
    state_next = state;
    if (bus.redirect_valid) begin
      state_next = (redirect_target < END_PC) ? RUN : DONE;
    end else begin
      case (state)
        RUN:     if (push && (pc_inc >= END_PC)) state_next = DRAIN;
        DRAIN:   if (count_next == '0) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= (RESET_PC >= END_PC) ? DONE : RUN;
    else        state <= state_next;
  end

  // Redirect wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_next == DONE);
      if (bus.redirect_valid) begin
        pc     <= redirect_target;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc_inc;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= pc;
      fifo_instr[wr_ptr] <= bus.imem_data;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.out_valid = valid_int;
  assign bus.out_instr = valid_int ? fifo_instr[rd_ptr] : '0;
  assign bus.out_pc    = valid_int ? fifo_pc[rd_ptr] : '0;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// ready/redirect traffic checked by a scoreboard against the expected PC stream.
module tb_instr_fetch_unit;

  localparam logic [31:0] END_PC = 32'd360;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_pc;
  logic [31:0] last_instr;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(
    .RESET_PC  (32'd0),
    .END_PC    (END_PC),
    .PC_STEP   (32'd4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h8E080200;
      32'd120: return 32'h8E08020C;
      32'd356: return 32'hAE0E0120;
      default: return {a[15:0] ^ 16'h5A5A, a[15:0] ^ 16'h0013};
    endcase
  endfunction

  assign bus.imem_data = rom_word(bus.imem_addr);

  task automatic check32(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Reference: after a (re)start at target T, decode must see T, T+4, ... up to END_PC.
  function automatic void load_expected(input logic [31:0] target);
    logic [31:0] p;
    exp_q.delete();
    p = {target[31:2], 2'b00};
    while (p < END_PC) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endfunction

  task automatic do_redirect(input logic [31:0] target);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    load_expected(target);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
  endtask

  // Scoreboard monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n && !bus.redirect_valid) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check32("pop_unexpected", bus.out_pc, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check32("pop_pc", bus.out_pc, e);
          check32("pop_instr", bus.out_instr, rom_word(e));
          last_pc    = bus.out_pc;
          last_instr = bus.out_instr;
        end
      end
      if (bus.done) begin
        check32("done_queue_empty", 32'(exp_q.size()), 32'd0);
        check32("done_valid_low", {31'd0, bus.out_valid}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit got_done, saw_drain, prev_valid;

    rst_n              = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    load_expected(32'd0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_imem_addr", bus.imem_addr, 32'd0);
    check32("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check32("rst_done", {31'd0, bus.done}, 32'd0);
    check32("rst_out_instr", bus.out_instr, 32'd0);
    check32("rst_out_pc", bus.out_pc, 32'd0);

    // Stall decode: exactly four words are prefetched, then the PC holds.
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check32("stall_imem_addr", bus.imem_addr, 32'd16);
    check32("stall_valid", {31'd0, bus.out_valid}, 32'd1);
    check32("stall_head_pc", bus.out_pc, 32'd0);
    check32("stall_head_instr", bus.out_instr, 32'h8E080200);

    @(posedge clk); #1 bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check32("stream_no_gap", {31'd0, bus.out_valid}, 32'd1);
    end

    // Build a 3-entry FIFO, then redirect to 120 with decode ready.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    do_redirect(32'd40);
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    do_redirect(32'd120);
    @(negedge clk);
    check32("redir_valid_low", {31'd0, bus.out_valid}, 32'd0);
    check32("redir_imem_addr", bus.imem_addr, 32'd120);
    @(negedge clk);
    check32("redir_valid_high", {31'd0, bus.out_valid}, 32'd1);
    check32("redir_out_pc", bus.out_pc, 32'd120);
    check32("redir_out_instr", bus.out_instr, 32'h8E08020C);

    @(posedge clk); #1;
    do_redirect(32'h7E);
    @(negedge clk);
    check32("unaligned_imem_addr", bus.imem_addr, 32'h7C);
    @(negedge clk);
    check32("unaligned_out_pc", bus.out_pc, 32'd124);

    // Random decode back-pressure and occasional redirects (some past END_PC).
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(29) == 0) do_redirect(32'($urandom_range(400)));
      else begin @(posedge clk); #1; end
    end

    // Free run to the end of the program.
    bus.out_ready = 1'b1;
    do_redirect(32'd200);
    got_done   = 1'b0;
    saw_drain  = 1'b0;
    prev_valid = 1'b0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      @(negedge clk);
      if (bus.done) got_done = 1'b1;
      else begin
        if (bus.imem_addr == END_PC && bus.out_valid) saw_drain = 1'b1;
        prev_valid = bus.out_valid;
      end
    end
    check32("end_done_seen", {31'd0, got_done}, 32'd1);
    check32("end_saw_drain", {31'd0, saw_drain}, 32'd1);
    check32("end_done_after_last_pop", {31'd0, prev_valid}, 32'd1);
    check32("end_valid_low", {31'd0, bus.out_valid}, 32'd0);
    check32("end_last_pc", last_pc, 32'd356);
    check32("end_last_instr", last_instr, 32'hAE0E0120);
    check32("end_imem_addr", bus.imem_addr, END_PC);
    check32("end_queue_empty", 32'(exp_q.size()), 32'd0);

    @(posedge clk); #1;
    do_redirect(32'd0);
    @(negedge clk);
    check32("restart_done_low", {31'd0, bus.done}, 32'd0);
    check32("restart_imem_addr", bus.imem_addr, 32'd0);
    @(negedge clk);
    check32("restart_out_pc", bus.out_pc, 32'd0);

    // Redirect beyond the program goes straight to DONE; async reset clears it.
    @(posedge clk); #1;
    do_redirect(32'd400);
    @(negedge clk);
    check32("far_redir_done", {31'd0, bus.done}, 32'd1);
    check32("far_redir_imem_addr", bus.imem_addr, 32'd400);
    @(posedge clk); #3;
    rst_n = 1'b0;
    load_expected(32'd0);
    #1;
    check32("async_rst_done_low", {31'd0, bus.done}, 32'd0);
    check32("async_rst_imem_addr", bus.imem_addr, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Fill the FIFO, then pulse reset between edges.
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check32("pre_pulse_valid", {31'd0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    load_expected(32'd0);
    #1;
    check32("pulse_valid_low", {31'd0, bus.out_valid}, 32'd0);
    check32("pulse_imem_addr", bus.imem_addr, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check32("pulse_fifo_empty", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check32("pulse_restart_valid", {31'd0, bus.out_valid}, 32'd1);
    check32("pulse_restart_pc", bus.out_pc, 32'd0);
    repeat (10) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
